// File: rtl/tohost_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tohost_pkg                                                        |
// | Brief  : tohost command encoding shared by the putc master and the slave.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package tohost_pkg;

   localparam int unsigned TOHOST_DEVICE_BIT_POS     = 56;
   localparam int unsigned TOHOST_COMMAND_BIT_POS    = 48;
   localparam logic [7:0]  TOHOST_DEVICE_CHAR        = 8'h01;
   localparam logic [7:0]  TOHOST_COMMAND_WRITE_CHAR = 8'h01;
   localparam logic [1:0]  AXI_RESP_OKAY             = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RESP = 2'd2
   } tohost_putc_state_e;

   function automatic logic [63:0] tohost_char_payload(input logic [7:0] ch);
      logic [63:0] payload;
      payload = (64'(TOHOST_DEVICE_CHAR) << TOHOST_DEVICE_BIT_POS)
              | (64'(TOHOST_COMMAND_WRITE_CHAR) << TOHOST_COMMAND_BIT_POS)
              | 64'(ch);
      return payload;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tohost_char_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tohost_char_fifo                                                  |
// | Brief  : Synchronous FIFO with wrap-bit pointers; DEPTH is a power of two. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tohost_char_fifo
   import tohost_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Storage needs no reset: emptiness is defined by the pointers alone.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/axi4lite_tohost_putc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axi4lite_tohost_putc                                              |
// | Brief  : Byte stream to tohost write-char AXI4-Lite writes, one in flight. |
// |          TOHOST_PUTC_ERRCNT_EN adds a saturating err_count output.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module axi4lite_tohost_putc
   import tohost_pkg::*;
#(
   parameter int unsigned      ALEN        = 32,
   parameter logic [ALEN-1:0]  TOHOST_ADDR = '0,
   parameter int unsigned      FIFO_DEPTH  = 8
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic            char_valid,
   input  logic [7:0]      char_data,
   output logic            char_ready,
   output logic            busy,
   output logic            err,
`ifdef TOHOST_PUTC_ERRCNT_EN
   output logic [15:0]     err_count,
`endif
   output logic            awvalid,
   input  logic            awready,
   output logic [ALEN-1:0] awaddr,
   output logic [2:0]      awprot,
   output logic            wvalid,
   input  logic            wready,
   output logic [63:0]     wdata,
   output logic [7:0]      wstrb,
   input  logic            bvalid,
   output logic            bready,
   input  logic [1:0]      bresp,
   output logic            arvalid,
   output logic            rready
);

   tohost_putc_state_e state_q, state_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        err_q, err_d;
   logic [63:0] wdata_q, wdata_d;
   logic        resp_err;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   logic [7:0]  fifo_head;

   assign char_ready = !fifo_full;

   tohost_char_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .push_i  (char_valid && !fifo_full),
      .data_i  (char_data),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      wdata_d   = wdata_q;
      fifo_pop  = 1'b0;
      resp_err  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               wdata_d   = tohost_char_payload(fifo_head);
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            // AW and W complete independently; B is awaited once both are done.
            if (awvalid_q && awready) awvalid_d = 1'b0;
            if (wvalid_q && wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (bvalid && bready_q) begin
               bready_d = 1'b0;
               resp_err = (bresp != AXI_RESP_OKAY);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      err_d = err_q | resp_err;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         err_q     <= 1'b0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         err_q     <= err_d;
         wdata_q   <= wdata_d;
      end
   end

`ifdef TOHOST_PUTC_ERRCNT_EN
   logic [15:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (resp_err && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) err_count_q <= '0;
      else          err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`endif

   assign busy    = !fifo_empty || (state_q != IDLE);
   assign err     = err_q;
   assign awvalid = awvalid_q;
   assign awaddr  = TOHOST_ADDR;
   assign awprot  = 3'b000;
   assign wvalid  = wvalid_q;
   assign wdata   = wdata_q;
   assign wstrb   = 8'hFF;
   assign bready  = bready_q;
   assign arvalid = 1'b0;
   assign rready  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_tohost_putc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_axi4lite_tohost_putc                                           |
// | Brief  : Scoreboard bench with a delay-configurable AXI4-Lite slave model. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_axi4lite_tohost_putc;

   localparam int unsigned     ALEN  = 32;
   localparam logic [ALEN-1:0] ADDR  = 32'h0;
   localparam int              DEPTH = 8;
   localparam logic [63:0]     HDR   = 64'h0101_0000_0000_0000;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic            char_valid;
   logic [7:0]      char_data;
   logic            char_ready, busy, err;
   logic            awvalid, awready;
   logic [ALEN-1:0] awaddr;
   logic [2:0]      awprot;
   logic            wvalid, wready;
   logic [63:0]     wdata;
   logic [7:0]      wstrb;
   logic            bvalid, bready;
   logic [1:0]      bresp;
   logic            arvalid, rready;
`ifdef TOHOST_PUTC_ERRCNT_EN
   logic [15:0]     err_count;
`endif

   always #5 aclk = ~aclk;

   axi4lite_tohost_putc #(
      .ALEN        (ALEN),
      .TOHOST_ADDR (ADDR),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .busy       (busy),
      .err        (err),
`ifdef TOHOST_PUTC_ERRCNT_EN
      .err_count  (err_count),
`endif
      .awvalid    (awvalid),
      .awready    (awready),
      .awaddr     (awaddr),
      .awprot     (awprot),
      .wvalid     (wvalid),
      .wready     (wready),
      .wdata      (wdata),
      .wstrb      (wstrb),
      .bvalid     (bvalid),
      .bready     (bready),
      .bresp      (bresp),
      .arvalid    (arvalid),
      .rready     (rready)
   );

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [1:0]  resp_q[$];
   int          aw_dly = -1, w_dly = -1, b_dly = -1;

   // Reference model: characters accepted, writes started, responses seen.
   int accepted, started, b_done, wcnt, occ, m_cnt;
   bit m_err;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic int pick(input int d);
      return (d < 0) ? int'($urandom_range(0, 3)) : d;
   endfunction

   // Slave: ready/valid delays drawn per transaction, response from resp_q.
   bit s_aw_hs, s_w_hs, s_b_hs, s_active, s_got_aw, s_got_w;
   int s_aw_wait, s_w_wait, s_b_wait;
   initial begin : slave
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      s_active = 0; s_got_aw = 0; s_got_w = 0;
      forever begin
         @(negedge aclk);
         s_aw_hs = awvalid && awready;
         s_w_hs  = wvalid && wready;
         s_b_hs  = bvalid && bready;
         @(posedge aclk); #1;
         if (!aresetn) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            s_active = 0; s_got_aw = 0; s_got_w = 0;
            resp_q.delete();
         end else begin
            if (s_aw_hs) begin awready = 1'b0; s_got_aw = 1; end
            if (s_w_hs)  begin wready  = 1'b0; s_got_w  = 1; end
            if (s_b_hs)  begin bvalid  = 1'b0; bresp = 2'b00; end
            if (!s_active && awvalid) begin
               s_active  = 1;
               s_aw_wait = pick(aw_dly);
               s_w_wait  = pick(w_dly);
               s_b_wait  = pick(b_dly);
            end
            if (s_active && !s_got_aw && !awready) begin
               if (s_aw_wait == 0) awready = 1'b1; else s_aw_wait--;
            end
            if (s_active && !s_got_w && !wready) begin
               if (s_w_wait == 0) wready = 1'b1; else s_w_wait--;
            end
            if (s_active && s_got_aw && s_got_w && !bvalid) begin
               if (s_b_wait == 0) begin
                  bvalid   = 1'b1;
                  bresp    = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                  s_active = 0; s_got_aw = 0; s_got_w = 0;
               end else begin
                  s_b_wait--;
               end
            end
         end
      end
   end

   // Monitor: sampled on the falling edge, compares against the model.
   bit          p_awv, p_wv, p_awhs, p_whs, m_aw_hs, m_w_hs;
   logic [63:0] p_wdata, e_wdata;
   initial begin : monitor
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            exp_q.delete();
            accepted = 0; started = 0; b_done = 0; wcnt = 0; m_cnt = 0; m_err = 0;
            p_awv = 0; p_wv = 0; p_awhs = 0; p_whs = 0; p_wdata = '0;
         end else begin
            if (awvalid && !p_awv) started++;
            occ = accepted - started;
            check(char_ready == (occ < DEPTH), "char_ready", 64'(char_ready), 64'(occ < DEPTH));
            check(busy == (occ > 0 || started > b_done), "busy", 64'(busy), 64'(occ > 0 || started > b_done));
            check(err == m_err, "err", 64'(err), 64'(m_err));
`ifdef TOHOST_PUTC_ERRCNT_EN
            check(err_count == m_cnt[15:0], "err_count", 64'(err_count), 64'(m_cnt));
`endif
            check(!arvalid && rready, "ar_r_tieoff", 64'({arvalid, rready}), 64'h1);
            check(!(bready && (awvalid || wvalid)), "bready_overlap", 64'({bready, awvalid, wvalid}), 64'h0);
            if (p_awv && !p_awhs) check(awvalid, "awvalid_hold", 64'(awvalid), 64'h1);
            if (p_awhs)           check(!awvalid, "awvalid_drop", 64'(awvalid), 64'h0);
            if (p_wv && !p_whs)   check(wvalid && wdata == p_wdata, "wdata_hold", wdata, p_wdata);
            if (p_whs)            check(!wvalid, "wvalid_drop", 64'(wvalid), 64'h0);
            m_aw_hs = awvalid && awready;
            m_w_hs  = wvalid && wready;
            if (m_aw_hs) check(awaddr == ADDR && awprot == 3'b000, "aw_addr", 64'({awprot, awaddr}), 64'(ADDR));
            if (m_w_hs) begin
               check(exp_q.size() != 0, "write_expected", wdata, 64'h0);
               if (exp_q.size() != 0) begin
                  e_wdata = exp_q.pop_front();
                  check(wdata == e_wdata, "wdata", wdata, e_wdata);
               end
               check(wstrb == 8'hFF, "wstrb", 64'(wstrb), 64'hFF);
               wcnt++;
            end
            if (bvalid && bready) begin
               check(wcnt == b_done + 1, "b_outstanding", 64'(wcnt), 64'(b_done + 1));
               b_done++;
               if (bresp != 2'b00) begin
                  m_err = 1;
                  if (m_cnt < 65535) m_cnt++;
               end
            end
            if (char_valid && char_ready) begin
               exp_q.push_back(HDR | {56'h0, char_data});
               accepted++;
            end
            p_awv = awvalid; p_wv = wvalid; p_awhs = m_aw_hs; p_whs = m_w_hs; p_wdata = wdata;
         end
      end
   end

   task automatic send_char(input logic [7:0] c);
      int t;
      t = 0;
      char_valid = 1'b1;
      char_data  = c;
      do begin
         @(negedge aclk);
         t++;
      end while (!char_ready && t < 1000);
      if (t >= 1000) check(1'b0, "send_timeout", 64'(c), 64'h0);
      @(posedge aclk); #1;
      char_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      do begin
         @(negedge aclk);
         t++;
      end while ((exp_q.size() != 0 || busy) && t < 3000);
      check(t < 3000, "drain_timeout", 64'(t), 64'd3000);
      @(posedge aclk); #1;
   endtask

   task automatic check_reset_values(input string tag);
      check(!awvalid && !wvalid && !bready, {tag, "_valids"}, 64'({awvalid, wvalid, bready}), 64'h0);
      check(!arvalid && rready, {tag, "_ar_r"}, 64'({arvalid, rready}), 64'h1);
      check(wdata == 64'h0, {tag, "_wdata"}, wdata, 64'h0);
      check(char_ready && !busy && !err, {tag, "_status"}, 64'({char_ready, busy, err}), 64'h4);
`ifdef TOHOST_PUTC_ERRCNT_EN
      check(err_count == 16'h0, {tag, "_err_count"}, 64'(err_count), 64'h0);
`endif
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int t;
      aresetn    = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      repeat (3) @(posedge aclk);
      #1;
      check_reset_values("reset");
      aresetn = 1'b1;

      // "hi\n" back to back, zero-latency slave.
      aw_dly = 0; w_dly = 0; b_dly = 0;
      send_char(8'h68);
      send_char(8'h69);
      send_char(8'h0A);
      drain();
      check(err == 1'b0, "hi_err", 64'(err), 64'h0);

      // Stalled B: one character in flight plus DEPTH buffered fills the FIFO.
      b_dly = 30;
      for (int i = 0; i < DEPTH + 1; i++) send_char(8'h30 + 8'(i));
      repeat (3) @(negedge aclk);
      check(!char_ready && busy, "fifo_full", 64'({char_ready, busy}), 64'h1);
      @(posedge aclk); #1;
      send_char(8'h39);
      drain();

      // AW accepted three cycles ahead of W.
      aw_dly = 0; w_dly = 3; b_dly = 0;
      send_char(8'h41);
      send_char(8'h42);
      drain();

      // A decode error sets err, which survives the following OKAY writes.
      aw_dly = -1; w_dly = -1; b_dly = -1;
      resp_q.push_back(2'b11);
      send_char(8'h58);
      send_char(8'h59);
      send_char(8'h5A);
      drain();
      check(err == 1'b1, "decerr_sticky", 64'(err), 64'h1);
`ifdef TOHOST_PUTC_ERRCNT_EN
      check(err_count == 16'd1, "decerr_count", 64'(err_count), 64'h1);
`endif

      // Random traffic with occasional SLVERR responses.
      for (int i = 0; i < 40; i++) resp_q.push_back(($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00);
      for (int i = 0; i < 40; i++) begin
         send_char(8'($urandom));
         repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      end
      drain();

      // Reset while a write sits in SEND with awvalid high.
      aw_dly = 50;
      send_char(8'h55);
      send_char(8'h56);
      t = 0;
      do begin @(negedge aclk); t++; end while (!awvalid && t < 100);
      check(t < 100, "awvalid_seen", 64'(t), 64'd100);
      @(posedge aclk); #3;
      aresetn = 1'b0;
      #1;
      check_reset_values("async_reset");
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      aw_dly = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         check(!busy && !awvalid && char_ready, "post_reset_empty", 64'({busy, awvalid, char_ready}), 64'h1);
      end
      @(posedge aclk); #1;
      send_char(8'h21);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
